bmp_assembler: RTL and testbench

BMP_ASSEMBLER -- requirements
Module: bmp_assembler

---
 rtl/bmp_assembler_if.sv | 26 ++
 rtl/bmp_assembler.sv | 101 ++++++++++
 tb/tb_bmp_assembler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bmp_assembler_if.sv
// rtl/bmp_assembler_if.sv - slice input, bitmap output and status bundle for bmp_assembler
interface bmp_assembler_if;
    logic          start;
    logic          mode;
    logic [63:0]   colin;
    logic          colvalid;
    logic          colready;
    logic [23:0]   rowin;
    logic          rowvalid;
    logic          rowready;
    logic [1535:0] bmpout;
    logic          bmpvalid;
    logic          bmpack;
    logic [6:0]    slicecount;
    logic          busy;

    modport master (
        output start, mode, colin, colvalid, rowin, rowvalid, bmpack,
        input  colready, rowready, bmpout, bmpvalid, slicecount, busy
    );

    modport slave (
        input  start, mode, colin, colvalid, rowin, rowvalid, bmpack,
        output colready, rowready, bmpout, bmpvalid, slicecount, busy
    );
endinterface

// File: rtl/bmp_assembler.sv
// rtl/bmp_assembler.sv - assembles a 1536-bit bitmap from 64-bit column or 24-bit row slices
module bmp_assembler #(
    parameter int COLS = 24,
    parameter int ROWS = 64
) (
    input  logic           clk,
    input  logic           rst,
    bmp_assembler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          mode_q;
    logic [1535:0] bmp_q;
    logic [6:0]    count_q;
    logic          accept;
    logic          last;
    logic          clear;
    logic [10:0]   col_base;
    logic [10:0]   row_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start seen in FILL wins over any slice offered in the same cycle.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        accept     = 1'b0;
        last       = mode_q ? (count_q == 7'(ROWS - 1)) : (count_q == 7'(COLS - 1));
        case (state)
            IDLE: begin
                if (bus.start) begin
                    clear      = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (bus.start) begin
                    clear = 1'b1;
                end else begin
                    accept = mode_q ? bus.rowvalid : bus.colvalid;
                    if (accept && last) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.bmpack) begin
                    if (bus.start) begin
                        clear      = 1'b1;
                        state_next = FILL;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Row base is count*24 built as count*16 + count*8.
    assign col_base = {count_q[4:0], 6'd0};
    assign row_base = {1'b0, count_q[5:0], 4'd0} + {2'b0, count_q[5:0], 3'd0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= 1'b0;
            bmp_q   <= '0;
            count_q <= '0;
        end else if (clear) begin
            mode_q  <= bus.mode;
            bmp_q   <= '0;
            count_q <= '0;
        end else if (accept) begin
            if (mode_q) begin
                bmp_q[row_base +: 24] <= bus.rowin;
            end else begin
                bmp_q[col_base +: 64] <= bus.colin;
            end
            count_q <= count_q + 7'd1;
        end
    end

    assign bus.colready   = (state == FILL) && !mode_q;
    assign bus.rowready   = (state == FILL) && mode_q;
    assign bus.bmpvalid   = (state == DONE);
    assign bus.busy       = (state != IDLE);
    assign bus.bmpout     = bmp_q;
    assign bus.slicecount = count_q;
endmodule

// File: tb/tb_bmp_assembler.sv
// tb/tb_bmp_assembler.sv - randomized self-checking bench for bmp_assembler
module tb_bmp_assembler;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    bmp_assembler_if bus ();

    bmp_assembler #(.COLS(24), .ROWS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 0 = idle, 1 = filling, 2 = bitmap complete
    int            m_phase;
    bit            m_mode;
    int            m_cnt;
    logic [1535:0] m_bmp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_mode  = 1'b0;
        m_cnt   = 0;
        m_bmp   = '0;
    endtask

    task automatic model_step(input bit s, input bit m, input bit cv, input logic [63:0] ci,
                              input bit rv, input logic [23:0] ri, input bit ak);
        int need;
        if (m_phase == 0) begin
            if (s) begin
                m_phase = 1; m_mode = m; m_cnt = 0; m_bmp = '0;
            end
        end else if (m_phase == 1) begin
            if (s) begin
                m_mode = m; m_cnt = 0; m_bmp = '0;
            end else if (!m_mode && cv) begin
                m_bmp[m_cnt*64 +: 64] = ci;
                m_cnt++;
            end else if (m_mode && rv) begin
                m_bmp[m_cnt*24 +: 24] = ri;
                m_cnt++;
            end
            need = m_mode ? 64 : 24;
            if (m_cnt == need) m_phase = 2;
        end else begin
            if (ak) begin
                if (s) begin
                    m_phase = 1; m_mode = m; m_cnt = 0; m_bmp = '0;
                end else begin
                    m_phase = 0;
                end
            end
        end
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".colready"}, 64'(bus.colready), 64'(m_phase == 1 && !m_mode));
        chk({where, ".rowready"}, 64'(bus.rowready), 64'(m_phase == 1 && m_mode));
        chk({where, ".bmpvalid"}, 64'(bus.bmpvalid), 64'(m_phase == 2));
        chk({where, ".busy"}, 64'(bus.busy), 64'(m_phase != 0));
        chk({where, ".slicecount"}, 64'(bus.slicecount), 64'(m_cnt));
        for (int w = 0; w < 24; w++) begin
            chk($sformatf("%s.bmpout[%0d]", where, w), bus.bmpout[w*64 +: 64], m_bmp[w*64 +: 64]);
        end
    endtask

    // Called at a falling edge: drive, clock once, then compare at the next falling edge.
    task automatic cyc(input string where, input bit s, input bit m, input bit cv, input logic [63:0] ci,
                       input bit rv, input logic [23:0] ri, input bit ak);
        bus.start = s; bus.mode = m; bus.colvalid = cv; bus.colin = ci;
        bus.rowvalid = rv; bus.rowin = ri; bus.bmpack = ak;
        @(posedge clk);
        model_step(s, m, cv, ci, rv, ri, ak);
        @(negedge clk);
        check_outputs(where);
    endtask

    task automatic async_reset(input string where);
        #2 rst = 1'b1;
        #1 model_reset();
        check_outputs(where);
        @(negedge clk);
        rst = 1'b0;
        check_outputs({where, "_rel"});
    endtask

    logic [1535:0] snap;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.colin = '0; bus.colvalid = 1'b0;
        bus.rowin = '0; bus.rowvalid = 1'b0; bus.bmpack = 1'b0;
        model_reset();
        #3 check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        cyc("idle", 0, 0, 1, 64'h1234, 1, 24'h55, 1);

        // Column fill with rows offered on the wrong port throughout
        cyc("col_start", 1, 0, 0, 0, 1, 24'hFFFFFF, 0);
        for (int c = 0; c < 24; c++) begin
            logic [63:0] cd;
            cd = 64'(c[5:0]);
            cyc("col_fill", 0, 0, 1, cd, 1, 24'($urandom), 0);
        end
        for (int c = 0; c < 24; c++) chk("col_word", bus.bmpout[c*64 +: 64], 64'(c));
        chk("col_count", 64'(bus.slicecount), 64'd24);
        snap = bus.bmpout;

        // Hold in DONE without ack; start must be ignored
        for (int i = 0; i < 10; i++) begin
            cyc("done_hold", (i % 3) == 1, 1, 1, {$urandom, $urandom}, 1, 24'($urandom), 0);
            chk("hold_valid", 64'(bus.bmpvalid), 64'd1);
            chk("hold_bmp_lo", bus.bmpout[63:0] ^ bus.bmpout[1535:1472], snap[63:0] ^ snap[1535:1472]);
        end
        cyc("ack", 0, 0, 0, 0, 0, 0, 1);
        cyc("idle_hold", 0, 1, 1, 64'hDEAD, 1, 24'hBEEF, 0);

        // Row fill with rowvalid dropped every third cycle
        cyc("row_start", 1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; m_phase == 1 && k < 200; k++) begin
            logic [23:0] rd;
            rd = 24'hA50000 | 24'(m_cnt);
            cyc("row_fill", 0, 0, 1, {$urandom, $urandom}, (k % 3) != 2, rd, 0);
        end
        for (int r = 0; r < 64; r++) chk("row_word", 64'(bus.bmpout[r*24 +: 24]), 64'(24'hA50000 | 24'(r)));
        chk("row_count", 64'(bus.slicecount), 64'd64);

        // Back-to-back: ack together with start into a column bitmap
        cyc("b2b", 1, 0, 1, 64'h77, 1, 24'h1, 1);
        chk("b2b_count", 64'(bus.slicecount), 64'd0);
        chk("b2b_valid", 64'(bus.bmpvalid), 64'd0);

        // Restart after 10 column slices, slice offered with start is dropped
        for (int c = 0; c < 10; c++) cyc("pre_restart", 0, 0, 1, {$urandom, $urandom}, 0, 0, 0);
        cyc("restart", 1, 0, 1, 64'hFACE, 0, 0, 0);
        chk("restart_count", 64'(bus.slicecount), 64'd0);
        chk("restart_w0", bus.bmpout[63:0], 64'd0);

        // Async reset after 5 slices, then no action until start
        for (int c = 0; c < 5; c++) cyc("pre_rst", 0, 0, 1, {$urandom, $urandom}, 0, 0, 0);
        async_reset("async_rst");
        for (int i = 0; i < 5; i++) cyc("post_rst", 0, 1, 1, {$urandom, $urandom}, 1, 24'($urandom), 1);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            cyc("rand", ($urandom_range(0, 99) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                {$urandom, $urandom}, ($urandom_range(0, 3) != 0), 24'($urandom),
                ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
